// File: rtl/wb_slave_buffer.sv
// Registered Wishbone classic buffer between one crossbar slave port and a peripheral.
// Every output is a flop; a hung slave is cut off with an error after TIMEOUT cycles.
module wb_slave_buffer #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cyc,
  input  logic          i_stb,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic [SW-1:0] i_sel,
  output logic          o_ack,
  output logic [DW-1:0] o_data,
  output logic          o_err,
  output logic          o_scyc,
  output logic          o_sstb,
  output logic          o_swe,
  output logic [AW-1:0] o_saddr,
  output logic [DW-1:0] o_sdata,
  output logic [SW-1:0] o_ssel,
  input  logic          i_sack,
  input  logic [DW-1:0] i_sdata,
  input  logic          i_serr,
  output logic          o_timeout
);

  localparam int TW      = $clog2(TIMEOUT + 1);
  // TIMEOUT=0 would give a zero-width counter; keep one bit so the logic stays legal.
  localparam int CW      = (TW > 0) ? TW : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_scyc, w_scyc_next;
  logic          r_sstb, w_sstb_next;
  logic          r_swe, w_swe_next;
  logic [AW-1:0] r_saddr, w_saddr_next;
  logic [DW-1:0] r_sdata, w_sdata_next;
  logic [SW-1:0] r_ssel, w_ssel_next;
  logic          r_ack, w_ack_next;
  logic          r_err, w_err_next;
  logic [DW-1:0] r_data, w_data_next;
  logic          r_timeout, w_timeout_next;

  logic          w_timeout_hit;
  logic [CW-1:0] w_cnt_inc;

  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CW'(TO_LAST));
  // Saturating increment: the counter never wraps even with the timeout disabled.
  assign w_cnt_inc     = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_scyc    <= 1'b0;
      r_sstb    <= 1'b0;
      r_swe     <= 1'b0;
      r_saddr   <= '0;
      r_sdata   <= '0;
      r_ssel    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_data    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_scyc    <= w_scyc_next;
      r_sstb    <= w_sstb_next;
      r_swe     <= w_swe_next;
      r_saddr   <= w_saddr_next;
      r_sdata   <= w_sdata_next;
      r_ssel    <= w_ssel_next;
      r_ack     <= w_ack_next;
      r_err     <= w_err_next;
      r_data    <= w_data_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_scyc_next    = r_scyc;
    w_sstb_next    = r_sstb;
    w_swe_next     = r_swe;
    w_saddr_next   = r_saddr;
    w_sdata_next   = r_sdata;
    w_ssel_next    = r_ssel;
    w_data_next    = r_data;
    w_ack_next     = 1'b0;
    w_err_next     = 1'b0;
    w_timeout_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_scyc_next = 1'b0;
        w_sstb_next = 1'b0;
        if (i_cyc && i_stb) begin
          w_swe_next   = i_we;
          w_saddr_next = i_addr;
          w_sdata_next = i_data;
          w_ssel_next  = i_sel;
          w_scyc_next  = 1'b1;
          w_sstb_next  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = S_REQ;
        end
      end

      S_REQ: begin
        w_cnt_next = w_cnt_inc;
        // Abort beats any slave response; slave error beats ack; both beat the timeout.
        if (!i_cyc) begin
          w_scyc_next  = 1'b0;
          w_sstb_next  = 1'b0;
          w_state_next = S_IDLE;
        end else if (i_serr) begin
          w_scyc_next  = 1'b0;
          w_sstb_next  = 1'b0;
          w_err_next   = 1'b1;
          w_data_next  = '0;
          w_state_next = S_RESP;
        end else if (i_sack) begin
          w_scyc_next  = 1'b0;
          w_sstb_next  = 1'b0;
          w_ack_next   = 1'b1;
          w_data_next  = r_swe ? '0 : i_sdata;
          w_state_next = S_RESP;
        end else if (w_timeout_hit) begin
          w_scyc_next    = 1'b0;
          w_sstb_next    = 1'b0;
          w_err_next     = 1'b1;
          w_timeout_next = 1'b1;
          w_data_next    = '0;
          w_state_next   = S_RESP;
        end
      end

      S_RESP: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_scyc_next  = 1'b0;
        w_sstb_next  = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_scyc    = r_scyc;
  assign o_sstb    = r_sstb;
  assign o_swe     = r_swe;
  assign o_saddr   = r_saddr;
  assign o_sdata   = r_sdata;
  assign o_ssel    = r_ssel;
  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_data    = r_data;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_wb_slave_buffer.sv
// Directed self-checking bench for wb_slave_buffer (TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_wb_slave_buffer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_cyc, i_stb, i_we;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic [SW-1:0] i_sel;
  logic          o_ack, o_err, o_timeout;
  logic [DW-1:0] o_data;
  logic          o_scyc, o_sstb, o_swe;
  logic [AW-1:0] o_saddr;
  logic [DW-1:0] o_sdata;
  logic [SW-1:0] o_ssel;
  logic          i_sack, i_serr;
  logic [DW-1:0] i_sdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_slave_buffer #(
    .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
    .i_addr(i_addr), .i_data(i_data), .i_sel(i_sel),
    .o_ack(o_ack), .o_data(o_data), .o_err(o_err),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sack(i_sack), .i_sdata(i_sdata), .i_serr(i_serr),
    .o_timeout(o_timeout)
  );

  task automatic bus_idle();
    i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0;
    i_addr = '0; i_data = '0; i_sel = '0;
    i_sack = 1'b0; i_serr = 1'b0; i_sdata = '0;
  endtask

  // Called on a falling edge: presents a request sampled by the next rising edge (cycle 0).
  task automatic drive_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
    i_cyc = 1'b1; i_stb = 1'b1; i_we = we; i_addr = a; i_data = d; i_sel = s;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    bus_idle();
    #1;
    checks++;
    if ({o_scyc, o_sstb, o_swe, o_ack, o_err, o_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000", {o_scyc, o_sstb, o_swe, o_ack, o_err, o_timeout});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({o_saddr, o_sdata, o_ssel, o_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h/%h exp all zero", o_saddr, o_sdata, o_ssel, o_data);
    end
    i_reset = 1'b0;
    @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_read();
    drive_req(1'b0, 32'h1000_0004, 32'h0, 4'hF);
    @(negedge clk); // cycle 1
    checks++;
    if (o_sstb !== 1'b1 || o_scyc !== 1'b1 || o_swe !== 1'b0) begin
      errors++;
      $display("FAIL read_strobe got cyc=%b stb=%b we=%b exp 1 1 0", o_scyc, o_sstb, o_swe);
    end
    // Upstream changes while the request is outstanding must not reach the slave.
    i_addr = 32'h3333_0000; i_data = 32'h5555_5555; i_we = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (o_sstb !== 1'b1 || o_ack !== 1'b0 || o_saddr !== 32'h1000_0004 || o_swe !== 1'b0) begin
        errors++;
        $display("FAIL read_hold c%0d got stb=%b ack=%b addr=%h we=%b exp 1 0 10000004 0",
                 c, o_sstb, o_ack, o_saddr, o_swe);
      end
    end
    i_sack = 1'b1; i_sdata = 32'hDEAD_BEEF; // slave acks in cycle 4
    @(negedge clk); // cycle 5
    i_sack = 1'b0; i_sdata = '0;
    i_cyc = 1'b0; i_stb = 1'b0;
    checks++;
    if (o_ack !== 1'b1 || o_err !== 1'b0 || o_data !== 32'hDEAD_BEEF || o_scyc !== 1'b0) begin
      errors++;
      $display("FAIL read_ack got ack=%b err=%b data=%h scyc=%b exp 1 0 deadbeef 0",
               o_ack, o_err, o_data, o_scyc);
    end
    @(negedge clk); // cycle 6
    checks++;
    if (o_ack !== 1'b0 || o_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_after got ack=%b data=%h exp 0 deadbeef", o_ack, o_data);
    end
    bus_idle();
    @(negedge clk);
    $display("read addr=10000004 data=%h", o_data);
  endtask

  task automatic test_write();
    drive_req(1'b1, 32'h2000_0010, 32'h1234_5678, 4'hF);
    @(negedge clk); // cycle 1
    checks++;
    if (o_sstb !== 1'b1 || o_swe !== 1'b1 || o_saddr !== 32'h2000_0010 ||
        o_sdata !== 32'h1234_5678 || o_ssel !== 4'hF) begin
      errors++;
      $display("FAIL write_fields got stb=%b we=%b addr=%h data=%h sel=%h exp 1 1 20000010 12345678 f",
               o_sstb, o_swe, o_saddr, o_sdata, o_ssel);
    end
    i_sack = 1'b1; i_sdata = 32'hFFFF_FFFF;
    @(negedge clk); // cycle 2
    i_sack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    checks++;
    if (o_ack !== 1'b1 || o_data !== 32'h0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL write_ack got ack=%b data=%h err=%b exp 1 00000000 0", o_ack, o_data, o_err);
    end
    bus_idle();
    @(negedge clk);
    $display("write addr=20000010 data=12345678");
  endtask

  task automatic test_timeout();
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    drive_req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_sstb === 1'b1) n++;
      if (o_err === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout_seen got no err in 40 cycles exp err");
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_len got %0d stb cycles exp %0d", n, TO);
    end
    checks++;
    if (o_timeout !== 1'b1 || o_scyc !== 1'b0 || o_ack !== 1'b0 || o_data !== 32'h0) begin
      errors++;
      $display("FAIL timeout_flags got to=%b scyc=%b ack=%b data=%h exp 1 0 0 0",
               o_timeout, o_scyc, o_ack, o_data);
    end
    i_cyc = 1'b0; i_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (o_err !== 1'b0 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got err=%b to=%b exp 0 0", o_err, o_timeout);
    end
    bus_idle();
    @(negedge clk);
    $display("timeout after %0d strobe cycles", n);
  endtask

  task automatic test_ack_err();
    drive_req(1'b0, 32'h5000_0000, 32'h0, 4'h3);
    @(negedge clk); // cycle 1
    i_sack = 1'b1; i_serr = 1'b1; i_sdata = 32'hAAAA_AAAA;
    @(negedge clk); // cycle 2
    i_sack = 1'b0; i_serr = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_ack !== 1'b0 || o_timeout !== 1'b0 || o_data !== 32'h0) begin
      errors++;
      $display("FAIL ack_err got err=%b ack=%b to=%b data=%h exp 1 0 0 0",
               o_err, o_ack, o_timeout, o_data);
    end
    bus_idle();
    @(negedge clk);
    $display("ack+err -> err");
  endtask

  task automatic test_abort();
    drive_req(1'b0, 32'h6000_0000, 32'h0, 4'hF);
    @(negedge clk); // cycle 1
    checks++;
    if (o_scyc !== 1'b1) begin
      errors++;
      $display("FAIL abort_start got scyc=%b exp 1", o_scyc);
    end
    i_cyc = 1'b0; i_stb = 1'b0;
    @(negedge clk); // cycle 2
    checks++;
    if (o_scyc !== 1'b0 || o_sstb !== 1'b0 || o_ack !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop got scyc=%b stb=%b ack=%b err=%b exp 0 0 0 0",
               o_scyc, o_sstb, o_ack, o_err);
    end
    // Abort on the very cycle the slave acks: the response is discarded.
    drive_req(1'b0, 32'h6000_0004, 32'h0, 4'hF);
    @(negedge clk);
    i_sack = 1'b1; i_sdata = 32'h1111_2222; i_cyc = 1'b0; i_stb = 1'b0;
    @(negedge clk);
    i_sack = 1'b0;
    checks++;
    if (o_ack !== 1'b0 || o_err !== 1'b0 || o_scyc !== 1'b0) begin
      errors++;
      $display("FAIL abort_on_ack got ack=%b err=%b scyc=%b exp 0 0 0", o_ack, o_err, o_scyc);
    end
    @(negedge clk);
    checks++;
    if (o_ack !== 1'b0 || o_sstb !== 1'b0) begin
      errors++;
      $display("FAIL abort_after got ack=%b stb=%b exp 0 0", o_ack, o_sstb);
    end
    bus_idle();
    $display("abort: no response");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addr_tab [3];
    logic [DW-1:0] data_tab [3];
    int strobes, acks;
    logic prev_stb;
    addr_tab[0] = 32'h7000_0000; data_tab[0] = 32'hCAFE_0001;
    addr_tab[1] = 32'h7000_0004; data_tab[1] = 32'hCAFE_0002;
    addr_tab[2] = 32'h7000_0008; data_tab[2] = 32'hCAFE_0003;
    strobes = 0; acks = 0; prev_stb = 1'b0;
    drive_req(1'b0, addr_tab[0], 32'h0, 4'hF);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      i_sack = 1'b0;
      if (o_ack === 1'b1) begin
        if (acks < 3) begin
          checks++;
          if (o_data !== data_tab[acks]) begin
            errors++;
            $display("FAIL b2b_data%0d got %h exp %h", acks, o_data, data_tab[acks]);
          end
          $display("b2b read %0d data=%h", acks, o_data);
        end
        acks++;
        if (acks >= 3) begin
          i_cyc = 1'b0; i_stb = 1'b0;
        end else begin
          i_addr = addr_tab[acks];
        end
      end
      if (o_sstb === 1'b1 && !prev_stb) begin
        if (strobes < 3) begin
          checks++;
          if (o_saddr !== addr_tab[strobes]) begin
            errors++;
            $display("FAIL b2b_addr%0d got %h exp %h", strobes, o_saddr, addr_tab[strobes]);
          end
          i_sack = 1'b1;
          i_sdata = data_tab[strobes];
        end
        strobes++;
      end
      prev_stb = o_sstb;
    end
    checks++;
    if (strobes != 3 || acks != 3) begin
      errors++;
      $display("FAIL b2b_count got strobes=%0d acks=%0d exp 3 3", strobes, acks);
    end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    @(negedge clk);
    #2;
    i_reset = 1'b1;
    #1; // still before the next rising edge
    checks++;
    if (o_scyc !== 1'b0 || o_sstb !== 1'b0 || o_ack !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got scyc=%b stb=%b ack=%b err=%b exp 0 0 0 0",
               o_scyc, o_sstb, o_ack, o_err);
    end
    bus_idle();
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    drive_req(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'h1);
    @(negedge clk);
    i_sack = 1'b1;
    @(negedge clk);
    i_sack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    checks++;
    if (o_ack !== 1'b1 || o_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_recover got ack=%b data=%h exp 1 0", o_ack, o_data);
    end
    bus_idle();
    @(negedge clk);
    $display("reset mid-transfer recovered");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ack_err();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_slave_buffer.md
Name: wb_slave_buffer

Overview:
Registered Wishbone classic buffer and timeout stage that sits directly downstream of one crossbar slave port, between the crossbar and a single slave peripheral.
- Breaks the combinational path from crossbar grant/mux logic to slave decode, and from slave ack/data back through the crossbar.
- Terminates any transfer the slave fails to acknowledge within TIMEOUT cycles with an error, so a hung peripheral cannot hold a crossbar grant forever.

Parameters:
AW, 32, address width
DW, 32, data width
SW, DW/8, byte-select width
TIMEOUT, 255, max cycles slave stb may stay unacknowledged; 0 disables timeout
TW, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_cyc  in  1  cycle, from crossbar slave port
i_stb  in  1  strobe, from crossbar
i_we  in  1  write enable, from crossbar
i_addr  in  AW  address, from crossbar
i_data  in  DW  write data, from crossbar
i_sel  in  SW  byte selects, from crossbar
o_ack  out  1  ack to crossbar
o_data  out  DW  read data to crossbar
o_err  out  1  error to crossbar
o_scyc  out  1  cycle to slave
o_sstb  out  1  strobe to slave
o_swe  out  1  write enable to slave
o_saddr  out  AW  address to slave
o_sdata  out  DW  write data to slave
o_ssel  out  SW  byte selects to slave
i_sack  in  1  slave ack
i_sdata  in  DW  slave read data
i_serr  in  1  slave error
o_timeout  out  1  one-cycle pulse when a timeout terminates a transfer

Behaviour:
- One clock (i_clk); reset is asynchronous and active-high (i_reset).
- Reset values:
  - state=IDLE, counter=0.
  - All outputs 0: o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel, o_ack, o_err, o_data, o_timeout.
- Classic (non-pipelined) Wishbone on both sides. All outputs are registered.
- IDLE:
  - Slave-side cyc/stb are 0.
  - If i_cyc&i_stb: latch i_we/i_addr/i_data/i_sel into the slave-side registers, set o_scyc=o_sstb=1, clear counter, go REQ.
- REQ: slave-side outputs hold the latched values; counter increments each cycle. Priority, highest first:
  - !i_cyc: abort. Drop o_scyc/o_sstb, go IDLE, no response.
  - i_serr: drop o_scyc/o_sstb, set o_err=1, o_data=0, go RESP.
  - i_sack: drop o_scyc/o_sstb, o_ack=1, o_data=i_sdata for reads or 0 for writes, go RESP.
  - TIMEOUT!=0 and counter==TIMEOUT-1: drop o_scyc/o_sstb, o_err=1, o_timeout=1, o_data=0, go RESP.
- RESP:
  - o_ack or o_err is high for exactly this one cycle.
  - Next cycle: clear o_ack/o_err/o_timeout, go IDLE. o_data holds its value until the next response.
- Latency: request sampled in cycle 0, o_sstb in cycle 1. Slave acks in cycle k means o_ack in cycle k+1.
- Back-to-back transfers: the master sees ack in the RESP cycle and presents the next request; IDLE samples it the following cycle. No request is lost or duplicated.
- Simultaneous events:
  - ack+err in the same cycle: err wins.
  - ack/err on the timeout cycle: the slave response wins and o_timeout stays 0.
  - i_cyc drop on the ack cycle: abort wins and the response is discarded.
- i_sack/i_serr while in IDLE or RESP are ignored.
- Upstream i_addr/i_data changes while in REQ do not affect slave-side outputs.
- Counter never wraps: it stops once the state leaves REQ.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously) and state returns to IDLE.

Test Plan:
- Read, slave acks 3 cycles after o_sstb with i_sdata=0xDEADBEEF -> o_ack one cycle, o_data=0xDEADBEEF, 4 cycles after o_sstb rose; o_scyc low the cycle after i_sack.
- Write addr=0x20000010, data=0x12345678, sel=0xF, immediate ack -> slave sees identical addr/data/sel/we; o_ack 2 cycles after request; o_data=0.
- TIMEOUT=16, slave never acks -> o_sstb high exactly 16 cycles; then o_err=1 and o_timeout=1 for one cycle; o_scyc=0.
- Slave asserts i_sack and i_serr together -> o_err=1, o_ack=0. Separately, i_cyc drops in REQ -> no ack/err, slave cyc drops next cycle.
- Three back-to-back reads with stb held continuously -> exactly three slave strobes and three acks in order, with correct per-transfer data.
- Assert i_reset while in REQ -> o_scyc/o_sstb/o_ack/o_err go 0 without a clock edge; the next request after release completes normally.
